// File: rtl/seq_multdiv_unit.sv
// rtl/seq_multdiv_unit.sv - iterative one-bit-per-cycle multiply/divide unit with HI/LO result
// Optional flush input is enabled by defining MDU_FLUSH_EN.
module seq_multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MDU_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             md,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_hi,
    output logic [WIDTH-1:0] alu_lo,
    output logic             multbusy,
    output logic             divbusy,
    output logic             multwrite,
    output logic             divwrite
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               div_q, div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               flush_w;
    logic               in_sa, in_sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

`ifdef MDU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        // Signs only matter for the signed ops (alu_op[0] == 0)
        in_sa = ~alu_op[0] & alu_a[WIDTH-1];
        in_sb = ~alu_op[0] & alu_b[WIDTH-1];
        mag_a = in_sa ? -alu_a : alu_a;
        mag_b = in_sb ? -alu_b : alu_b;

        // acc holds {upper, multiplier} for MULT and {remainder, dividend/quotient} for DIV
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
        div_part = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = div_part >= {1'b0, opnd_q};
        div_diff = div_part[WIDTH-1:0] - opnd_q;

        prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (md) begin
                    state_d = S_RUN;
                    div_d   = alu_op[1];
                    sa_d    = in_sa;
                    sb_d    = in_sb;
                    opnd_d  = alu_op[1] ? mag_b : mag_a;
                    acc_d   = {{WIDTH{1'b0}}, (alu_op[1] ? mag_a : mag_b)};
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    acc_d = {(div_ge ? div_diff : div_part[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (div_q) begin
                    // Zero divisor leaves remainder = |a|; re-signing it restores the raw dividend
                    hi_d = rem;
                    lo_d = (opnd_q == '0) ? {WIDTH{1'b1}} : quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_w && state_q != S_IDLE) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    assign alu_hi    = hi_q;
    assign alu_lo    = lo_q;
    assign multbusy  = (state_q != S_IDLE) && !div_q;
    assign divbusy   = (state_q != S_IDLE) &&  div_q;
    assign multwrite = (state_q == S_DONE) && !div_q && !flush_w;
    assign divwrite  = (state_q == S_DONE) &&  div_q && !flush_w;

endmodule

// File: tb/tb_seq_multdiv_unit.sv
// tb/tb_seq_multdiv_unit.sv - self-checking bench for seq_multdiv_unit against an arithmetic reference
module tb_seq_multdiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        md = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [31:0] alu_hi, alu_lo;
    logic        multbusy, divbusy, multwrite, divwrite;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [63:0] cur_exp;
    logic        cur_div;

    seq_multdiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MDU_FLUSH_EN
        .flush     (flush),
`endif
        .md        (md),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_hi    (alu_hi),
        .alu_lo    (alu_lo),
        .multbusy  (multbusy),
        .divbusy   (divbusy),
        .multwrite (multwrite),
        .divwrite  (divwrite)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = sa * sb;
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        md      = 1'b1;
        alu_op  = op;
        alu_a   = a;
        alu_b   = b;
        cur_exp = model(op, a, b);
        cur_div = op[1];
        t0      = cyc;
    endtask

    task automatic finish_accept();
        step();
        md     = 1'b0;
        alu_op = 2'($urandom);
        alu_a  = $urandom;
        alu_b  = $urandom;
    endtask

    task automatic wait_write(input string tag);
        int bad_busy = 0;
        bit got = 0;
        while (!got && (cyc - t0) < 60) begin
            if (cur_div ? (divbusy !== 1'b1 || multbusy !== 1'b0)
                        : (multbusy !== 1'b1 || divbusy !== 1'b0)) bad_busy++;
            if (multwrite === 1'b1 || divwrite === 1'b1) got = 1;
            else step();
        end
        check({tag, "_latency"}, 64'(cyc - t0), 64'd34);
        check({tag, "_pulse"}, {62'b0, multwrite, divwrite}, cur_div ? 64'd1 : 64'd2);
        check({tag, "_hilo"}, {alu_hi, alu_lo}, cur_exp);
        check({tag, "_busy"}, 64'(bad_busy), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle"}, {60'b0, multbusy, divbusy, multwrite, divwrite}, 64'd0);
        check({tag, "_hold"}, {alu_hi, alu_lo}, cur_exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        drive_start(op, a, b);
        finish_accept();
        wait_write(tag);
        step();
        check_idle(tag);
    endtask

    initial begin
        logic [63:0] prev;
        int seen;

        step();
        step();
        check("reset_hilo", {alu_hi, alu_lo}, 64'd0);
        check("reset_flags", {60'b0, multbusy, divbusy, multwrite, divwrite}, 64'd0);
        rst = 1'b0;
        step();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_const", {alu_hi, alu_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_const", {alu_hi, alu_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_const", {alu_hi, alu_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7);
        check("divu_const", {alu_hi, alu_lo}, {32'd2, 32'd14});
        run_op("divu_zero", 2'b11, 32'h1234, 32'h0);
        check("divu_zero_const", {alu_hi, alu_lo}, {32'h1234, 32'hFFFF_FFFF});
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'h0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {alu_hi, alu_lo}, {32'h0, 32'h8000_0000});

        // start request while running is dropped
        drive_start(2'b01, 32'd1000, 32'd3);
        finish_accept();
        repeat (5) step();
        md = 1'b1; alu_op = 2'b11; alu_a = 32'd9; alu_b = 32'd4;
        step();
        md = 1'b0;
        wait_write("md_in_run");
        step();
        check_idle("md_in_run");

        // back-to-back accept in the DONE cycle
        drive_start(2'b10, 32'hFFFF_FC18, 32'd7);
        finish_accept();
        wait_write("b2b_first");
        drive_start(2'b00, 32'h0001_0003, 32'hFFFF_0005);
        finish_accept();
        wait_write("b2b_second");
        step();
        check_idle("b2b_second");

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 2'($urandom), pick(), pick());
        end

        // asynchronous reset partway through a divide
        drive_start(2'b10, 32'd12345, 32'd67);
        finish_accept();
        while ((cyc - t0) < 10) step();
        rst = 1'b1;
        #2;
        check("rst_mid_hilo", {alu_hi, alu_lo}, 64'd0);
        check("rst_mid_flags", {60'b0, multbusy, divbusy, multwrite, divwrite}, 64'd0);
        step();
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            step();
            if (divwrite || multwrite || divbusy || multbusy) seen++;
        end
        check("rst_mid_quiet", 64'(seen), 64'd0);

`ifdef MDU_FLUSH_EN
        run_op("pre_flush", 2'b01, 32'd77, 32'd11);
        prev = {alu_hi, alu_lo};
        drive_start(2'b11, 32'd5000, 32'd9);
        finish_accept();
        while ((cyc - t0) < 20) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", {62'b0, multbusy, divbusy}, 64'd0);
        check("flush_hold", {alu_hi, alu_lo}, prev);
        seen = 0;
        repeat (40) begin
            step();
            if (divwrite || multwrite) seen++;
        end
        check("flush_nowrite", 64'(seen), 64'd0);
`else
        prev = {alu_hi, alu_lo};
`endif
        check("final_quiet", {alu_hi, alu_lo}, prev);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
